// File: rtl/serial_to_parallel_if.sv
// rtl/serial_to_parallel_if.sv - serial input / parallel output bundle for serial_to_parallel
interface serial_to_parallel_if;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic       byte_strobe;

   // Upstream side: supplies the serial stream, observes recovered bytes
   modport master (
      output data_in,
      input  data_out,
      input  valid_out,
      input  active,
      input  byte_strobe
   );

   // Deserializer side
   modport slave (
      input  data_in,
      output data_out,
      output valid_out,
      output active,
      output byte_strobe
   );
endinterface

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - comma-aligned serial to parallel byte deserializer
module serial_to_parallel #(
   parameter logic [7:0] IDLE_BYTE  = 8'hBC,
   parameter int         SYNC_COUNT = 4
) (
   input  logic                 clk_8f,
   input  logic                 reset_L,
   serial_to_parallel_if.slave  bus
);

   localparam int              BC_W   = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(SYNC_COUNT);
   localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);

   typedef enum logic [1:0] {UNLOCKED, SYNC, ACTIVE} state_t;

   state_t          state, state_nxt;
   logic [6:0]      shift_q;
   logic [2:0]      bit_cnt, bit_cnt_nxt;
   logic [BC_W-1:0] bc_cnt, bc_cnt_nxt;
   logic [7:0]      data_q, data_nxt;
   logic            valid_q, valid_nxt;
   logic            strobe_q, strobe_nxt;

   logic [7:0]      candidate;
   logic            is_idle;
   logic            boundary;

   // The byte ending on this edge includes the bit being sampled right now
   assign candidate = {shift_q, bus.data_in};
   assign is_idle   = (candidate == IDLE_BYTE);
   assign boundary  = (bit_cnt == 3'd7);

   // State and datapath registers; reset drops lock and any partial byte at once
   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         state    <= UNLOCKED;
         shift_q  <= '0;
         bit_cnt  <= '0;
         bc_cnt   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         shift_q  <= candidate[6:0];
         bit_cnt  <= bit_cnt_nxt;
         bc_cnt   <= bc_cnt_nxt;
         data_q   <= data_nxt;
         valid_q  <= valid_nxt;
         strobe_q <= strobe_nxt;
      end
   end

   // Alignment search, comma counting and lock
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt + 3'd1;
      bc_cnt_nxt  = bc_cnt;
      case (state)
         UNLOCKED: begin
            // Slide one bit per edge until a comma lines up; that edge becomes byte 0
            bit_cnt_nxt = '0;
            if (is_idle) begin
               bc_cnt_nxt = BC_ONE;
               state_nxt  = (SYNC_COUNT <= 1) ? ACTIVE : SYNC;
            end
         end
         SYNC: begin
            if (boundary) begin
               if (is_idle) begin
                  if (bc_cnt != BC_MAX) bc_cnt_nxt = bc_cnt + BC_ONE;
                  if (bc_cnt >= BC_MAX - BC_ONE) state_nxt = ACTIVE;
               end else begin
                  // A broken comma run throws alignment away; search restarts next edge
                  state_nxt   = UNLOCKED;
                  bc_cnt_nxt  = '0;
                  bit_cnt_nxt = '0;
               end
            end
         end
         ACTIVE: begin
            // Lock is sticky until reset
         end
         default: begin
            state_nxt   = UNLOCKED;
            bit_cnt_nxt = '0;
            bc_cnt_nxt  = '0;
         end
      endcase
   end

   // Byte delivery once locked; idle bytes strobe but keep the last data byte
   always_comb begin
      data_nxt   = data_q;
      valid_nxt  = valid_q;
      strobe_nxt = 1'b0;
      if (state == ACTIVE && boundary) begin
         strobe_nxt = 1'b1;
         if (is_idle) begin
            valid_nxt = 1'b0;
         end else begin
            data_nxt  = candidate;
            valid_nxt = 1'b1;
         end
      end
   end

   assign bus.data_out    = data_q;
   assign bus.valid_out   = valid_q;
   assign bus.byte_strobe = strobe_q;
   assign bus.active      = (state == ACTIVE);

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - directed scoreboard bench for serial_to_parallel
module tb_serial_to_parallel;

   localparam logic [7:0] IDLE = 8'hBC;

   logic clk_8f;
   logic reset_L;

   serial_to_parallel_if bus ();

   serial_to_parallel #(
      .IDLE_BYTE  (IDLE),
      .SYNC_COUNT (4)
   ) dut (
      .clk_8f  (clk_8f),
      .reset_L (reset_L),
      .bus     (bus)
   );

   initial clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   int         checks;
   int         failures;
   logic [8:0] sb_q[$];
   logic       tb_locked;
   logic       hold_valid;
   logic [7:0] hold_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},   32'(bus.data_out),    32'h0);
      check({tag, "_valid"},  32'(bus.valid_out),   32'h0);
      check({tag, "_active"}, 32'(bus.active),      32'h0);
      check({tag, "_strobe"}, 32'(bus.byte_strobe), 32'h0);
   endtask

   // One serial bit per edge; outputs are sampled 1 time unit after the edge
   task automatic send_bit(input logic b);
      bus.data_in = b;
      @(posedge clk_8f);
      #1;
   endtask

   function automatic logic [7:0] serializer(input logic [7:0] d, input logic v);
      return v ? d : IDLE;
   endfunction

   // MSB-first byte; when locked, the expected result is queued as it is driven
   task automatic send_byte(input logic [7:0] b, input logic act_after);
      logic [8:0] e;
      if (tb_locked) sb_q.push_back((b != IDLE) ? {1'b1, b} : {1'b0, hold_data});
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         if (i != 0) begin
            check("strobe_mid", 32'(bus.byte_strobe), 32'h0);
            check("valid_hold", 32'(bus.valid_out),   32'(hold_valid));
            check("data_hold",  32'(bus.data_out),    32'(hold_data));
         end else if (tb_locked) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $error("FAIL sb_empty observed=0 expected=1");
            end else begin
               e = sb_q.pop_front();
               check("strobe_bnd", 32'(bus.byte_strobe), 32'h1);
               check("valid_bnd",  32'(bus.valid_out),   32'(e[8]));
               check("data_bnd",   32'(bus.data_out),    32'(e[7:0]));
               hold_valid = e[8];
               hold_data  = e[7:0];
            end
         end else begin
            check("strobe_unlk", 32'(bus.byte_strobe), 32'h0);
            check("valid_unlk",  32'(bus.valid_out),   32'h0);
            check("data_unlk",   32'(bus.data_out),    32'h0);
         end
      end
      check("active", 32'(bus.active), 32'(act_after));
      tb_locked = act_after;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      tb_locked  = 1'b0;
      hold_valid = 1'b0;
      hold_data  = 8'h00;
      reset_L    = 1'b0;
      bus.data_in = 1'b0;

      repeat (3) @(posedge clk_8f);
      #1;
      check_all_zero("reset");
      @(negedge clk_8f);
      reset_L = 1'b1;

      // Lock after three random bits and four commas
      repeat (3) send_bit(1'($urandom_range(0, 1)));
      send_byte(IDLE, 1'b0);
      send_byte(IDLE, 1'b0);
      send_byte(IDLE, 1'b0);
      send_byte(IDLE, 1'b1);

      // Data bytes
      send_byte(8'hB5, 1'b1);
      send_byte(8'hD2, 1'b1);

      // Idle byte in the middle of data
      send_byte(8'hA5, 1'b1);
      send_byte(IDLE,  1'b1);
      send_byte(8'h3C, 1'b1);

      // Upstream serializer loopback
      send_byte(serializer(8'hB5, 1'b1), 1'b1);
      send_byte(serializer(8'hD6, 1'b1), 1'b1);
      send_byte(serializer(8'hE8, 1'b0), 1'b1);

      // Mid-byte asynchronous reset while active
      send_byte(8'h5A, 1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      #3;
      reset_L = 1'b0;
      #1;
      check_all_zero("async_rst");
      bus.data_in = 1'b0;
      @(negedge clk_8f);
      reset_L    = 1'b1;
      sb_q.delete();
      tb_locked  = 1'b0;
      hold_valid = 1'b0;
      hold_data  = 8'h00;

      // Failed sync, then full relock
      send_byte(IDLE,  1'b0);
      send_byte(IDLE,  1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(IDLE,  1'b0);
      send_byte(IDLE,  1'b0);
      send_byte(IDLE,  1'b0);
      send_byte(IDLE,  1'b1);
      send_byte(8'h81, 1'b1);

      check("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
